// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
// Stall holds the stage, flush inserts a bubble, and outputs are zeroed while the stage is empty.
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_use_imm,
    input  logic [OP_W-1:0]       in_op,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  fwd_mem_we,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic [XLEN-1:0]       alu_a,
    output logic [XLEN-1:0]       alu_b,
    output logic [OP_W-1:0]       alu_op,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
    output logic [XLEN-1:0]       out_store_data
);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]       imm_q, imm_d;
    logic                  use_imm_q, use_imm_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic [XLEN-1:0]       rs1_fwd;
    logic [XLEN-1:0]       rs2_fwd;

    // x0 always reads zero; the younger MEM result wins over WB.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       stored
    );
        if (addr == '0)
            return '0;
        else if (fwd_mem_we && (fwd_mem_rd == addr))
            return fwd_mem_data;
        else if (fwd_wb_we && (fwd_wb_rd == addr))
            return fwd_wb_data;
        else
            return stored;
    endfunction

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        op_d        = op_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rd_addr_d   = rd_addr_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            op_d        = '0;
        end else if (stall) begin
            // A WB write retiring while we are held must not be lost once WB moves on.
            if (fwd_wb_we && (fwd_wb_rd == rs1_addr_q) && (rs1_addr_q != '0))
                rs1_data_d = fwd_wb_data;
            if (fwd_wb_we && (fwd_wb_rd == rs2_addr_q) && (rs2_addr_q != '0))
                rs2_data_d = fwd_wb_data;
        end else begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write & in_valid;
            op_d        = in_op;
            rs1_addr_d  = in_rs1_addr;
            rs2_addr_d  = in_rs2_addr;
            rs1_data_d  = in_rs1_data;
            rs2_data_d  = in_rs2_data;
            imm_d       = in_imm;
            use_imm_d   = in_use_imm;
            rd_addr_d   = in_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            op_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            op_q        <= op_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    always_comb begin
        rs1_fwd = fwd_operand(rs1_addr_q, rs1_data_q);
        rs2_fwd = fwd_operand(rs2_addr_q, rs2_data_q);
    end

    assign in_ready       = !stall;
    assign out_valid      = valid_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_reg_write  = reg_write_q & valid_q;
    assign out_store_data = rs2_fwd;
    assign alu_op         = valid_q ? op_q : '0;
    assign alu_a          = valid_q ? rs1_fwd : '0;
    assign alu_b          = valid_q ? (use_imm_q ? imm_q : rs2_fwd) : '0;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, load, forwarding priority, stall refresh,
// flush over stall and immediate select, with hand-computed expected values.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [3:0]  in_op;
    logic [4:0]  in_rd_addr;
    logic        in_reg_write;
    logic        stall;
    logic        flush;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;
    logic [31:0] out_store_data;

    int n_checks = 0;
    int n_pass   = 0;

    ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .OP_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1_addr    (in_rs1_addr),
        .in_rs2_addr    (in_rs2_addr),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_imm         (in_imm),
        .in_use_imm     (in_use_imm),
        .in_op          (in_op),
        .in_rd_addr     (in_rd_addr),
        .in_reg_write   (in_reg_write),
        .stall          (stall),
        .flush          (flush),
        .fwd_mem_we     (fwd_mem_we),
        .fwd_mem_rd     (fwd_mem_rd),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_we      (fwd_wb_we),
        .fwd_wb_rd      (fwd_wb_rd),
        .fwd_wb_data    (fwd_wb_data),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .out_valid      (out_valid),
        .out_rd_addr    (out_rd_addr),
        .out_reg_write  (out_reg_write),
        .out_store_data (out_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_rs1_addr  = '0;
        in_rs2_addr  = '0;
        in_rs1_data  = '0;
        in_rs2_data  = '0;
        in_imm       = '0;
        in_use_imm   = 1'b0;
        in_op        = '0;
        in_rd_addr   = '0;
        in_reg_write = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        fwd_mem_we   = 1'b0;
        fwd_mem_rd   = '0;
        fwd_mem_data = '0;
        fwd_wb_we    = 1'b0;
        fwd_wb_rd    = '0;
        fwd_wb_data  = '0;
    endtask

    task automatic load(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [3:0] op, input logic use_imm, input logic [31:0] imm,
                        input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        in_rs1_addr  = rs1;
        in_rs1_data  = d1;
        in_rs2_addr  = rs2;
        in_rs2_data  = d2;
        in_op        = op;
        in_use_imm   = use_imm;
        in_imm       = imm;
        in_rd_addr   = rd;
        in_reg_write = rw;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_op",      {28'd0, alu_op}, 32'd0);
        check("rst_a",       alu_a, 32'd0);
        check("rst_b",       alu_b, 32'd0);
        check("rst_rw",      {31'd0, out_reg_write}, 32'd0);
        check("rst_rd",      {27'd0, out_rd_addr}, 32'd0);
        check("rst_ready",   {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("idle_valid",  {31'd0, out_valid}, 32'd0);

        // Plain load, no forwarding
        load(5'd1, 32'd10, 5'd2, 32'd5, 4'h2, 1'b0, 32'd0, 5'd4, 1'b1);
        tick();
        check("load_a",      alu_a, 32'd10);
        check("load_b",      alu_b, 32'd5);
        check("load_op",     {28'd0, alu_op}, 32'd2);
        check("load_valid",  {31'd0, out_valid}, 32'd1);
        check("load_rw",     {31'd0, out_reg_write}, 32'd1);
        check("load_rd",     {27'd0, out_rd_addr}, 32'd4);
        check("load_store",  out_store_data, 32'd5);

        // Reset asserted between edges clears outputs without a clock
        load(5'd1, 32'd10, 5'd2, 32'd5, 4'h1, 1'b0, 32'd0, 5'd6, 1'b1);
        tick();
        check("pre_rst_op",  {28'd0, alu_op}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",  {31'd0, out_valid}, 32'd0);
        check("arst_op",     {28'd0, alu_op}, 32'd0);
        check("arst_a",      alu_a, 32'd0);
        check("arst_b",      alu_b, 32'd0);
        check("arst_rw",     {31'd0, out_reg_write}, 32'd0);
        idle_inputs();
        tick();
        rst_n = 1'b1;

        // Forwarding priority on rs1 = x3
        load(5'd3, 32'd7, 5'd0, 32'd0, 4'h2, 1'b0, 32'd0, 5'd5, 1'b1);
        tick();
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'd111;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'd222;
        #1;
        check("fwd_mem_pri", alu_a, 32'd111);
        fwd_mem_we = 1'b0;
        #1;
        check("fwd_wb",      alu_a, 32'd222);
        fwd_wb_we = 1'b0;
        #1;
        check("fwd_none",    alu_a, 32'd7);
        load(5'd0, 32'd55, 5'd0, 32'd0, 4'h2, 1'b0, 32'd0, 5'd5, 1'b1);
        tick();
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd111;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'd222;
        #1;
        check("fwd_x0",      alu_a, 32'd0);
        idle_inputs();

        // Stall with a WB retire to the held rs2 = x7
        load(5'd1, 32'd1, 5'd7, 32'd5, 4'h3, 1'b0, 32'd0, 5'd8, 1'b1);
        tick();
        check("st_pre_b",    alu_b, 32'd5);
        stall = 1'b1;
        load(5'd1, 32'd1, 5'd7, 32'd1234, 4'h9, 1'b0, 32'd0, 5'd9, 1'b1);
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'd99;
        #1;
        check("st_ready",    {31'd0, in_ready}, 32'd0);
        tick();
        fwd_wb_we = 1'b0;
        #1;
        check("st_b_kept",   alu_b, 32'd99);
        check("st_op_held",  {28'd0, alu_op}, 32'd3);
        check("st_rd_held",  {27'd0, out_rd_addr}, 32'd8);
        tick();
        check("st_b_2nd",    alu_b, 32'd99);
        stall = 1'b0;
        #1;
        check("st_b_rel",    alu_b, 32'd99);
        check("st_ready_rel", {31'd0, in_ready}, 32'd1);
        idle_inputs();

        // Flush wins over stall on the same edge
        load(5'd1, 32'd3, 5'd2, 32'd4, 4'h5, 1'b0, 32'd0, 5'd10, 1'b1);
        tick();
        check("fl_pre_rw",   {31'd0, out_reg_write}, 32'd1);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("fl_valid",    {31'd0, out_valid}, 32'd0);
        check("fl_rw",       {31'd0, out_reg_write}, 32'd0);
        check("fl_op",       {28'd0, alu_op}, 32'd0);
        check("fl_a",        alu_a, 32'd0);
        check("fl_b",        alu_b, 32'd0);
        idle_inputs();

        // Immediate selects ALU B while store data still forwards rs2
        load(5'd1, 32'd20, 5'd9, 32'd1, 4'h6, 1'b1, 32'hFFFF_FFFC, 5'd11, 1'b1);
        tick();
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd9; fwd_mem_data = 32'd50;
        #1;
        check("imm_b",       alu_b, 32'hFFFF_FFFC);
        check("imm_store",   out_store_data, 32'd50);
        check("imm_a",       alu_a, 32'd20);

        // Invalid input clears reg_write even when requested
        idle_inputs();
        in_reg_write = 1'b1;
        in_op = 4'h7;
        tick();
        check("inv_rw",      {31'd0, out_reg_write}, 32'd0);
        check("inv_op",      {28'd0, alu_op}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
